mdl_disp_arb: RTL and testbench

//  Shares the 4-digit seven-segment display mux between up to four requesters.

---
 rtl/mdl_disp_arb_pkg.sv | 18 +
 rtl/mdl_disp_arb_if.sv | 30 +++
 rtl/mdl_disp_arb_rr_pick.sv | 31 +++
 rtl/mdl_disp_arb.sv | 125 ++++++++++++
 tb/tb_mdl_disp_arb.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mdl_disp_arb_pkg.sv
// Shared definitions for the display-mux arbiter: FSM state codes,
// blank segment pattern, client count and a one-hot helper.
package mdl_disp_arb_pkg;

    localparam int unsigned CLIENT_N = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    // Active-low segments: all ones turns every segment off.
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    function automatic logic [CLIENT_N-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mdl_disp_arb_if.sv
// Client-side bus of the display arbiter.
//   req    : per-client level request (bit i = client i)
//   frame  : packed client frames, client i at [32*i+31:32*i] = {d3,d2,d1,d0}
//   gnt    : one-hot grant, zero when nobody owns the display
//   in3..0 : digit patterns forwarded to mdl_disp_mux
//   busy   : arbiter is showing or blanking
// master = client/requester side, slave = arbiter side.
interface mdl_disp_arb_if;
    import mdl_disp_arb_pkg::*;

    logic [CLIENT_N-1:0]    req;
    logic [32*CLIENT_N-1:0] frame;
    logic [CLIENT_N-1:0]    gnt;
    logic [7:0]             in3;
    logic [7:0]             in2;
    logic [7:0]             in1;
    logic [7:0]             in0;
    logic                   busy;

    modport master (
        output req, frame,
        input  gnt, in3, in2, in1, in0, busy
    );

    modport slave (
        input  req, frame,
        output gnt, in3, in2, in1, in0, busy
    );

endinterface

// File: rtl/mdl_disp_arb_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : most recently granted client
//   valid : some request is set
//   win   : first requester found searching last+1, last+2, last+3, last
module mdl_rr_pick
    import mdl_disp_arb_pkg::*;
(
    input  logic [CLIENT_N-1:0] req,
    input  logic [1:0]          last,
    output logic                valid,
    output logic [1:0]          win
);

    logic [1:0] idx;

    always_comb begin
        valid = 1'b0;
        win   = last;
        idx   = '0;
        // k = CLIENT_N wraps to last itself, so the previous owner comes last.
        for (int unsigned k = 1; k <= CLIENT_N; k++) begin
            idx = last + 2'(k);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/mdl_disp_arb.sv
// Display-mux arbiter: grants the 4-digit seven-segment display to one of
// four clients at a time, round-robin, with a minimum hold time and a
// blank gap between owners.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mdl_disp_arb_if (req/frame in, gnt/in3..in0/busy out)
module mdl_disp_arb
    import mdl_disp_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYC  = 50_000_000,
    parameter int unsigned BLANK_CYC = 2_500_000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic          clk,
    input  logic          reset_n,
    mdl_disp_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [31:0]      disp_q, disp_d;

    logic                pick_valid;
    logic [1:0]          pick_win;
    logic                owner_req;
    logic [CLIENT_N-1:0] others_req;
    logic [31:0]         owner_frame;

    mdl_rr_pick u_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .win   (pick_win)
    );

    assign owner_req   = bus.req[owner_q];
    assign others_req  = bus.req & ~onehot4(owner_q);
    assign owner_frame = bus.frame[{owner_q, 5'b0} +: 32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_SHOW;
                    owner_d = pick_win;
                    last_d  = pick_win;
                    cnt_d   = HOLD_LD;
                end
            end
            S_SHOW: begin
                // Owner release wins over hold expiry in the same cycle.
                if (!owner_req) begin
                    if (|others_req) begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == '0) begin
                    if (|others_req) begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pick_valid) begin
                    state_d = S_SHOW;
                    owner_d = pick_win;
                    last_d  = pick_win;
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Frame shows only while ownership continues; entering SHOW still
        // outputs blank, and leaving SHOW blanks together with gnt dropping.
        disp_d = (state_q == S_SHOW && state_d == S_SHOW) ? owner_frame : {4{SSEG_BLANK}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            last_q  <= 2'd3;
            disp_q  <= {4{SSEG_BLANK}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.gnt  = (state_q == S_SHOW) ? onehot4(owner_q) : '0;
    assign bus.in3  = disp_q[31:24];
    assign bus.in2  = disp_q[23:16];
    assign bus.in1  = disp_q[15:8];
    assign bus.in0  = disp_q[7:0];
    assign bus.busy = (state_q == S_SHOW) || (state_q == S_BLANK);

endmodule

// File: tb/tb_mdl_disp_arb.sv
// Self-checking bench for mdl_disp_arb with HOLD_CYC=8, BLANK_CYC=3.
// Each step pushes the expected {gnt, digits, busy} for the cycle being
// driven and pops it after the following rising edge.
module tb_mdl_disp_arb;

    localparam logic [31:0] BL = 32'hFFFF_FFFF;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    string phase;

    logic [31:0] frm [4];
    logic [36:0] exp_q [$];

    mdl_disp_arb_if bus ();

    mdl_disp_arb #(
        .HOLD_CYC  (8),
        .BLANK_CYC (3),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_frames();
        bus.frame = {frm[3], frm[2], frm[1], frm[0]};
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [31:0] ed, input logic eb);
        logic [36:0] e;
        bus.req = r;
        exp_q.push_back({eg, ed, eb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({phase, "/gnt"},  {28'd0, bus.gnt}, {28'd0, e[36:33]});
        check_val({phase, "/disp"}, {bus.in3, bus.in2, bus.in1, bus.in0}, e[32:1]);
        check_val({phase, "/busy"}, {31'd0, bus.busy}, {31'd0, e[0]});
    endtask

    initial begin
        int c;
        logic [3:0] g;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        bus.req = '0;
        frm[0] = 32'h1122_3344;
        frm[1] = 32'hC0F9_A4B0;
        frm[2] = 32'h5566_7788;
        frm[3] = 32'h99AA_BBCC;
        load_frames();

        // 1. Reset holds outputs idle while inputs toggle.
        phase = "rst";
        step(4'b1111, 4'b0000, BL, 1'b0);
        step(4'b0101, 4'b0000, BL, 1'b0);
        frm[2] = 32'h0000_0000;
        load_frames();
        step(4'b1010, 4'b0000, BL, 1'b0);
        frm[2] = 32'h5566_7788;
        load_frames();
        bus.req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        phase = "rst_rel";
        step(4'b0000, 4'b0000, BL, 1'b0);
        step(4'b0000, 4'b0000, BL, 1'b0);

        // 2. Single client holds indefinitely, reload without blanking.
        phase = "single";
        step(4'b0010, 4'b0010, BL, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0010, 4'b0010, frm[1], 1'b1);
        // Owner frame passes through; non-owner frame is ignored.
        phase = "passthru";
        frm[1] = 32'h8092_B0F8;
        frm[0] = 32'h1234_5678;
        load_frames();
        for (int i = 0; i < 8; i++) step(4'b0010, 4'b0010, frm[1], 1'b1);

        // 5. Release with nobody waiting goes straight to idle.
        phase = "rel_idle";
        step(4'b0000, 4'b0000, BL, 1'b0);
        step(4'b0000, 4'b0000, BL, 1'b0);

        // Fresh reset so the rotation starts at client 0.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // 3. Round-robin with everyone requesting.
        phase = "rr";
        for (int n = 0; n < 5; n++) begin
            c = n % 4;
            g = 4'(1 << c);
            step(4'b1111, g, BL, 1'b1);
            for (int i = 0; i < 7; i++) step(4'b1111, g, frm[c], 1'b1);
            if (n < 4) begin
                for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, BL, 1'b1);
            end
        end
        // Drop at the hold-expiry edge: release wins, nobody waits -> idle.
        phase = "rr_end";
        step(4'b0000, 4'b0000, BL, 1'b0);

        // 4. Early release with client 0 waiting.
        phase = "early";
        step(4'b0100, 4'b0100, BL, 1'b1);
        step(4'b0101, 4'b0100, frm[2], 1'b1);
        step(4'b0101, 4'b0100, frm[2], 1'b1);
        step(4'b0001, 4'b0000, BL, 1'b1);
        step(4'b0001, 4'b0000, BL, 1'b1);
        step(4'b0001, 4'b0000, BL, 1'b1);
        step(4'b0001, 4'b0001, BL, 1'b1);
        step(4'b0001, 4'b0001, frm[0], 1'b1);
        step(4'b0000, 4'b0000, BL, 1'b0);

        // 6. Asynchronous reset in the middle of SHOW.
        phase = "midrst";
        step(4'b1111, 4'b0010, BL, 1'b1);
        step(4'b1111, 4'b0010, frm[1], 1'b1);
        step(4'b1111, 4'b0010, frm[1], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst/gnt",  {28'd0, bus.gnt}, 32'd0);
        check_val("midrst/disp", {bus.in3, bus.in2, bus.in1, bus.in0}, BL);
        check_val("midrst/busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        phase = "after_rst";
        step(4'b1111, 4'b0001, BL, 1'b1);
        step(4'b1111, 4'b0001, frm[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
